// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage: instruction fields, control-flow
// encodings and the fetch controller state.
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // True for words that redirect the PC (jumps, branches, register jumps).
    function automatic logic is_ctrl_flow(input logic [31:0] word);
        logic [5:0] op;
        logic [5:0] fn;
        op = word[OPCODE_LSB +: 6];
        fn = word[FUNCT_LSB +: 6];
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_RTYPE) && ((fn == FUNCT_JR) || (fn == FUNCT_JALR)));
    endfunction

endpackage

// File: rtl/instr_fetch_npc_sel.sv
// Next-PC selection for the fetch stage: jr > jump > branch > sequential,
// plus a word-alignment check on the chosen target.
module npc_sel (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // NOTE: next_pc gets a default before the priority chain so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_addr;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// PC register, instruction ROM and RUN/HALT/FAULT fetch controller. The ROM image is
// passed in as IMEM_INIT, word i occupying bits [32*i +: 32].
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0]              RESET_PC   = 32'h0000_0000,
    parameter int                       IMEM_WORDS = 256,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT  = '0,
    parameter logic [31:0]              HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jaddr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    fetch_state_t state;
    logic [31:0]  word_index;
    logic         in_range;
    logic [31:0]  rom_word;
    logic [31:0]  next_pc;
    logic         misaligned;

    assign word_index = (pc - RESET_PC) >> 2;
    assign in_range   = word_index < 32'(IMEM_WORDS);
    assign rom_word   = IMEM_INIT[{word_index[IDX_W-1:0], 5'b0} +: 32];
    assign pc_plus4   = pc + 32'd4;

    assign instr       = (state == RUN && in_range) ? rom_word : NOP_WORD;
    assign instr_valid = (state == RUN) && in_range && (rom_word != HALT_WORD);

    assign opcode = instr[OPCODE_LSB +: 6];
    assign rs     = instr[RS_LSB +: 5];
    assign rt     = instr[RT_LSB +: 5];
    assign rd     = instr[RD_LSB +: 5];
    assign shamt  = instr[SHAMT_LSB +: 5];
    assign funct  = instr[FUNCT_LSB +: 6];
    assign imm    = instr[15:0];
    assign jaddr  = instr[25:0];

    assign halted = (state == HALT);
    assign fault  = (state == FAULT);

    // Redirect controls only count while a real instruction is being fetched.
    npc_sel u_npc_sel (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken & instr_valid),
        .branch_offset (branch_offset),
        .jump          (jump & instr_valid),
        .jump_target   (jump_target),
        .jr            (jr & instr_valid),
        .jr_addr       (jr_addr),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    // NOTE: all state here is registered with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= RUN;
            instr_count <= '0;
        end else if (state == RUN && !stall) begin
            if (instr_valid) begin
                instr_count <= instr_count + 32'd1;
            end
            if (!in_range) begin
                state <= FAULT;
            end else if (misaligned) begin
                state <= FAULT;
            end else if (rom_word == HALT_WORD) begin
                state <= HALT;
            end else begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural fetch model.
module tb_instr_fetch;

    localparam int          WORDS = 256;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    function automatic logic [31:0] image_word(input int i);
        case (i)
            0: return 32'h8C01_0004;
            1: return 32'h2002_0005;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            default: begin
                if (i % 61 == 0) return HALT;
                return ((32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678) & 32'h7FFF_FFFF;
            end
        endcase
    endfunction

    function automatic logic [WORDS*32-1:0] build_image();
        logic [WORDS*32-1:0] img;
        img = '0;
        for (int i = 0; i < WORDS; i++) img[32*i +: 32] = image_word(i);
        return img;
    endfunction

    localparam logic [WORDS*32-1:0] IMG       = build_image();
    localparam logic [127:0]        SMALL_IMG = {32'h2004_0001, 32'h2003_0002, 32'h2002_0003, 32'h2001_0004};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;

    logic [31:0] pc, pc_plus4, instr, instr_count, s_pc, s_pc_plus4, s_instr, s_instr_count;
    logic        instr_valid, halted, fault, s_instr_valid, s_halted, s_fault;
    logic [5:0]  opcode, funct, s_opcode, s_funct;
    logic [4:0]  rs, rt, rd, shamt, s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] imm, s_imm;
    logic [25:0] jaddr, s_jaddr;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .IMEM_INIT(IMG), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target), .jr(jr),
        .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
        .instr_valid(instr_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm(imm), .jaddr(jaddr), .halted(halted),
        .fault(fault), .instr_count(instr_count)
    );

    instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(4), .IMEM_INIT(SMALL_IMG), .HALT_WORD(HALT)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target), .jr(jr),
        .jr_addr(jr_addr), .pc(s_pc), .pc_plus4(s_pc_plus4), .instr(s_instr),
        .instr_valid(s_instr_valid), .opcode(s_opcode), .rs(s_rs), .rt(s_rt), .rd(s_rd),
        .shamt(s_shamt), .funct(s_funct), .imm(s_imm), .jaddr(s_jaddr), .halted(s_halted),
        .fault(s_fault), .instr_count(s_instr_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_controls();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; jr = 1'b0; jr_addr = '0;
    endtask

    task automatic apply_reset();
        clear_controls();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; jr = 1'b1; jr_addr = $urandom; jump = 1'b1;
        branch_taken = 1'b1; branch_offset = $urandom; jump_target = 26'($urandom);
        step();
        step();
        rst = 1'b0;
        clear_controls();
        checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); else passed++;
        checks++; if (instr_count !== 32'h0) $display("FAIL reset_count: got %0d expected 0", instr_count); else passed++;
        checks++; if ({halted, fault} !== 2'b00) $display("FAIL reset_state: got halted=%b fault=%b expected 0 0", halted, fault); else passed++;
        checks++; if (instr !== 32'h8C01_0004) $display("FAIL reset_instr: got %h expected 8c010004", instr); else passed++;
        checks++; if ({opcode, rs, rt, imm} !== {6'h23, 5'd0, 5'd1, 16'h0004})
            $display("FAIL reset_fields: got op=%h rs=%0d rt=%0d imm=%h expected op=23 rs=0 rt=1 imm=0004", opcode, rs, rt, imm);
        else passed++;
        checks++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4: got %h expected 4", pc_plus4); else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic        exp_v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc !== exp_pc[i]) $display("FAIL seq_pc%0d: got %h expected %h", i, pc, exp_pc[i]); else passed++;
            checks++; if (instr_valid !== exp_v[i]) $display("FAIL seq_valid%0d: got %b expected %b", i, instr_valid, exp_v[i]); else passed++;
            checks++; if (halted !== 1'b0) $display("FAIL seq_not_halted%0d: got %b expected 0", i, halted); else passed++;
            step();
        end
        checks++; if (halted !== 1'b1) $display("FAIL seq_halted: got %b expected 1", halted); else passed++;
        checks++; if (pc !== 32'hC) $display("FAIL seq_halt_pc: got %h expected c", pc); else passed++;
        checks++; if (instr_count !== 32'd3) $display("FAIL seq_count: got %0d expected 3", instr_count); else passed++;
        checks++; if ({instr, instr_valid} !== 33'h0) $display("FAIL seq_halt_instr: got %h/%b expected 0/0", instr, instr_valid); else passed++;
        jr = 1'b1; jr_addr = 32'h20;
        step(); step();
        clear_controls();
        checks++; if ({pc, halted} !== {32'hC, 1'b1}) $display("FAIL seq_halt_absorb: got pc=%h halted=%b expected c 1", pc, halted); else passed++;
    endtask

    task automatic test_branch();
        apply_reset();
        step(); step();
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step();
        clear_controls();
        checks++; if (pc !== 32'h4) $display("FAIL branch_back: got %h expected 4", pc); else passed++;
        step();
        branch_taken = 1'b1; branch_offset = 32'h0000_0003;
        step();
        clear_controls();
        checks++; if (pc !== 32'd24) $display("FAIL branch_fwd: got %h expected 18", pc); else passed++;
        checks++; if (instr !== image_word(6)) $display("FAIL branch_instr: got %h expected %h", instr, image_word(6)); else passed++;
    endtask

    task automatic test_priority();
        apply_reset();
        jump = 1'b1; jr = 1'b1; branch_taken = 1'b1; jr_addr = 32'h40;
        jump_target = 26'($urandom_range(1, 200)); branch_offset = 32'($urandom_range(1, 50));
        step();
        clear_controls();
        checks++; if (pc !== 32'h40) $display("FAIL prio_jr: got %h expected 40", pc); else passed++;
        jump = 1'b1; jump_target = 26'h10;
        step();
        clear_controls();
        checks++; if (pc !== 32'h40) $display("FAIL prio_jump: got %h expected 40", pc); else passed++;
        checks++; if (instr_count !== 32'd2) $display("FAIL prio_count: got %0d expected 2", instr_count); else passed++;
    endtask

    task automatic test_fault_reset();
        jr = 1'b1; jr_addr = 32'h42;
        step();
        clear_controls();
        checks++; if (fault !== 1'b1) $display("FAIL fault_flag: got %b expected 1", fault); else passed++;
        checks++; if (pc !== 32'h40) $display("FAIL fault_pc: got %h expected 40", pc); else passed++;
        checks++; if ({instr, instr_valid} !== 33'h0) $display("FAIL fault_instr: got %h/%b expected 0/0", instr, instr_valid); else passed++;
        jr = 1'b1; jr_addr = 32'h8;
        step(); step();
        checks++; if ({pc, fault} !== {32'h40, 1'b1}) $display("FAIL fault_absorb: got pc=%h fault=%b expected 40 1", pc, fault); else passed++;
        apply_reset();
        checks++; if ({pc, fault, instr_count} !== {32'h0, 1'b0, 32'h0})
            $display("FAIL fault_reset: got pc=%h fault=%b count=%0d expected 0 0 0", pc, fault, instr_count);
        else passed++;
    endtask

    task automatic test_stall();
        apply_reset();
        step();
        stall = 1'b1; jr = 1'b1; jr_addr = 32'h80; branch_taken = 1'b1; branch_offset = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({pc, instr_count} !== {32'h4, 32'd1})
                $display("FAIL stall_hold%0d: got pc=%h count=%0d expected 4 1", i, pc, instr_count);
            else passed++;
        end
        clear_controls();
        step();
        checks++; if ({pc, instr_count} !== {32'h8, 32'd2}) $display("FAIL stall_release: got pc=%h count=%0d expected 8 2", pc, instr_count); else passed++;
        step();
        stall = 1'b1;
        step(); step();
        checks++; if ({pc, halted} !== {32'hC, 1'b0}) $display("FAIL stall_on_halt: got pc=%h halted=%b expected c 0", pc, halted); else passed++;
        stall = 1'b0;
        step();
        checks++; if ({pc, halted} !== {32'hC, 1'b1}) $display("FAIL stall_halt_release: got pc=%h halted=%b expected c 1", pc, halted); else passed++;
    endtask

    task automatic test_out_of_range();
        apply_reset();
        for (int i = 0; i < 4; i++) step();
        checks++; if ({s_pc, s_instr_valid, s_fault} !== {32'd16, 1'b0, 1'b0})
            $display("FAIL oor_edge: got pc=%h valid=%b fault=%b expected 10 0 0", s_pc, s_instr_valid, s_fault);
        else passed++;
        step();
        checks++; if ({s_pc, s_instr_valid, s_fault} !== {32'd16, 1'b0, 1'b1})
            $display("FAIL oor_fault: got pc=%h valid=%b fault=%b expected 10 0 1", s_pc, s_instr_valid, s_fault);
        else passed++;
        checks++; if (s_instr_count !== 32'd4) $display("FAIL oor_count: got %0d expected 4", s_instr_count); else passed++;
    endtask

    // Behavioural model: state 0=run, 1=halt, 2=fault.
    task automatic test_random();
        logic [31:0] m_pc, tgt, word, e_instr;
        logic [31:0] m_cnt;
        int          m_st, off;
        logic        e_valid;
        apply_reset();
        m_pc = 32'h0; m_cnt = 32'h0; m_st = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst          = (($urandom_range(0, 99) == 0) || (m_st != 0 && $urandom_range(0, 3) == 0));
            stall        = ($urandom_range(0, 7) == 0);
            jr           = ($urandom_range(0, 9) == 0);
            jr_addr      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1100)) : 32'($urandom_range(0, 255)) << 2;
            jump         = ($urandom_range(0, 9) == 0);
            jump_target  = 26'($urandom_range(0, 300));
            branch_taken = ($urandom_range(0, 3) == 0);
            off          = int'($urandom_range(0, 40)) - 20;
            branch_offset = 32'(off);
            if (rst) begin
                m_pc = 32'h0; m_st = 0; m_cnt = 32'h0;
            end else if (m_st == 0 && !stall) begin
                if ((m_pc >> 2) >= WORDS) m_st = 2;
                else begin
                    word = image_word(int'(m_pc >> 2));
                    if (word == HALT) m_st = 1;
                    else begin
                        m_cnt = m_cnt + 1;
                        if (jr) tgt = jr_addr;
                        else if (jump) tgt = {m_pc[31:28] + 4'((m_pc + 4) >> 28) - m_pc[31:28], jump_target, 2'b00};
                        else if (branch_taken) tgt = m_pc + 4 + branch_offset * 4;
                        else tgt = m_pc + 4;
                        if (tgt % 4 != 0) m_st = 2;
                        else m_pc = tgt;
                    end
                end
            end
            step();
            e_instr = (m_st == 0 && (m_pc >> 2) < WORDS) ? image_word(int'(m_pc >> 2)) : 32'h0;
            e_valid = (m_st == 0) && ((m_pc >> 2) < WORDS) && (e_instr != HALT);
            checks++; if (pc !== m_pc) $display("FAIL rand_pc@%0d: got %h expected %h", cyc, pc, m_pc); else passed++;
            checks++; if (instr_count !== m_cnt) $display("FAIL rand_count@%0d: got %0d expected %0d", cyc, instr_count, m_cnt); else passed++;
            checks++; if ({halted, fault} !== {m_st == 1, m_st == 2})
                $display("FAIL rand_state@%0d: got halted=%b fault=%b expected %b %b", cyc, halted, fault, m_st == 1, m_st == 2);
            else passed++;
            checks++; if ({instr, instr_valid} !== {e_instr, e_valid})
                $display("FAIL rand_instr@%0d: got %h/%b expected %h/%b", cyc, instr, instr_valid, e_instr, e_valid);
            else passed++;
        end
        rst = 1'b0;
        clear_controls();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_fault_reset();
        test_stall();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
